// File: rtl/tx_shift_if.sv
// Word-in / serial-out bundle for tx_shift: upstream word handshake, bit-rate
// strobe, and the serial line with its frame status flags.
interface tx_shift_if #(
  parameter int DATA_W = 8
) ();
  logic              tick_en;
  logic              din_valid;
  logic [DATA_W-1:0] din;
  logic              din_ready;
  logic              ser_out;
  logic              busy;
  logic              done;

  // Handshake: a word transfers on a rising edge where din_valid and din_ready
  // are both 1; din is sampled only then, and ignored while busy.
  modport master (
    output tick_en, din_valid, din,
    input  din_ready, ser_out, busy, done
  );

  modport slave (
    input  tick_en, din_valid, din,
    output din_ready, ser_out, busy, done
  );
endinterface

// File: rtl/tx_shift.sv
// Tick-paced serial transmitter: start bit, DATA_W bits LSB first, optional
// even parity, stop bit. The start-bit edge is aligned to a tick after acceptance.
module tx_shift #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  tx_shift_if.slave  bus,
  output logic [2:0] o_dbg_state
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_PAR   = 3'd4,
    S_STOP  = 3'd5
  } state_t;

  state_t            r_state;
  logic              r_ser_out;
  logic              r_done;
  logic              r_par;
  logic [DATA_W-1:0] r_shift;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ser_out <= 1'b1;
      r_done    <= 1'b0;
      r_par     <= 1'b0;
      r_shift   <= '0;
      r_cnt     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        // A tick arriving with the word is deliberately not acted on here.
        S_IDLE: begin
          if (bus.din_valid) begin
            r_shift <= bus.din;
            r_par   <= ^bus.din;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (bus.tick_en) begin
            r_ser_out <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (bus.tick_en) begin
            r_ser_out <= r_shift[0];
            r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
            r_cnt     <= '0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus.tick_en) begin
            if (r_cnt < CNT_LAST) begin
              r_ser_out <= r_shift[0];
              r_shift   <= {1'b0, r_shift[DATA_W-1:1]};
              r_cnt     <= r_cnt + 1'b1;
            end else if (PARITY_EN) begin
              r_ser_out <= r_par;
              r_state   <= S_PAR;
            end else begin
              r_ser_out <= 1'b1;
              r_state   <= S_STOP;
            end
          end
        end
        S_PAR: begin
          if (bus.tick_en) begin
            r_ser_out <= 1'b1;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bus.tick_en) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ser_out <= 1'b1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.din_ready = (r_state == S_IDLE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.ser_out   = r_ser_out;
  assign bus.done      = r_done;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_tx_shift.sv
// Bench for tx_shift: one instance without and one with parity, driven by the
// same stimulus and each checked every cycle against a frame-level model.
module tb_tx_shift;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_en = 1'b0;
  logic         din_valid = 1'b0;
  logic [N-1:0] din = '0;
  logic [2:0]   dbg0, dbg1;

  int checks = 0;
  int failures = 0;

  tx_shift_if #(.DATA_W(N)) u_if0 ();
  tx_shift_if #(.DATA_W(N)) u_if1 ();

  assign u_if0.tick_en   = tick_en;
  assign u_if0.din_valid = din_valid;
  assign u_if0.din       = din;
  assign u_if1.tick_en   = tick_en;
  assign u_if1.din_valid = din_valid;
  assign u_if1.din       = din;

  tx_shift #(.DATA_W(N), .PARITY_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave), .o_dbg_state(dbg0));
  tx_shift #(.DATA_W(N), .PARITY_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave), .o_dbg_state(dbg1));

  // ---------------- clock / tick generation ----------------
  always #5 clk = ~clk;

  initial begin : tick_gen
    int tcnt;
    tcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt + 1) % 4;
      tick_en = (tcnt == 0);
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  // Each accepted word becomes a list of line levels, one per tick; the tick
  // after the list is exhausted ends the frame.
  bit        m_on = 1'b0;
  bit        m_busy [2];
  bit        m_line [2];
  bit        m_done [2];
  logic [15:0] m_frame [2];
  int        m_left [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_busy[d] = 1'b0;
        m_line[d] = 1'b1;
        m_done[d] = 1'b0;
        m_left[d] = 0;
        m_on      = 1'b1;
      end else begin
        m_done[d] = 1'b0;
        if (!m_busy[d]) begin
          if (din_valid) begin
            m_busy[d]  = 1'b1;
            m_frame[d] = 16'(din) << 1;
            if (d == 1) begin
              m_frame[d][N+1] = ^din;
              m_frame[d][N+2] = 1'b1;
              m_left[d] = N + 3;
            end else begin
              m_frame[d][N+1] = 1'b1;
              m_left[d] = N + 2;
            end
          end
        end else if (tick_en) begin
          if (m_left[d] > 0) begin
            m_line[d]  = m_frame[d][0];
            m_frame[d] = m_frame[d] >> 1;
            m_left[d]  = m_left[d] - 1;
          end else begin
            m_busy[d] = 1'b0;
            m_done[d] = 1'b1;
            m_line[d] = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- scoreboard: per-cycle compare ----------------
  logic [3:0] exp_q[$];

  always @(negedge clk) begin
    if (m_on) begin
      for (int d = 0; d < 2; d++)
        exp_q.push_back({m_line[d], m_busy[d], ~m_busy[d], m_done[d]});
      check("cycle_dut0", {u_if0.ser_out, u_if0.busy, u_if0.din_ready, u_if0.done}, exp_q.pop_front());
      check("cycle_dut1", {u_if1.ser_out, u_if1.busy, u_if1.din_ready, u_if1.done}, exp_q.pop_front());
    end
  end

  // ---------------- raw line log and done counters ----------------
  bit         logging = 1'b0;
  logic [3:0] log_q[$];
  int         dc0 = 0;
  int         dc1 = 0;

  always @(negedge clk) begin
    if (logging) log_q.push_back({u_if0.ser_out, u_if0.done, u_if1.ser_out, u_if1.done});
    if (u_if0.done === 1'b1) dc0++;
    if (u_if1.done === 1'b1) dc1++;
  end

  // ---------------- driver tasks ----------------
  task automatic send_pulse(input logic [N-1:0] w);
    @(posedge clk); #1;
    din = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((u_if0.busy || u_if1.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n >= 200), 32'd0);
  endtask

  // Checks a logged frame against a literal bit sequence: every bit held for
  // exactly four cycles, and the done pulse one tick after the stop bit starts.
  task automatic frame_check(input string name, input int d, input string seq);
    int first, dn, idx, ndone;
    logic [3:0] e;
    logic [3:0] s;
    first = -1;
    dn = -1;
    ndone = 0;
    for (int i = 0; i < log_q.size(); i++) begin
      e = log_q[i];
      if (first < 0 && ((d == 0) ? e[3] : e[1]) == 1'b0) first = i;
      if ((d == 0) ? e[2] : e[0]) begin
        ndone++;
        if (dn < 0) dn = i;
      end
    end
    check({name, "_start_seen"}, 32'(first >= 0), 32'd1);
    if (first < 0) first = 0;
    for (int k = 0; k < seq.len(); k++) begin
      for (int j = 0; j < 4; j++) begin
        idx = first + 4 * k + j;
        e = (idx < log_q.size()) ? log_q[idx] : 4'bxxxx;
        s[j] = (d == 0) ? e[3] : e[1];
      end
      check($sformatf("%s_bit%0d", name, k), 32'(s), (seq[k] == "1") ? 32'hF : 32'h0);
    end
    check({name, "_done_offset"}, 32'(dn - first), 32'(4 * seq.len()));
    check({name, "_done_count"}, 32'(ndone), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int n;
    int snap0, snap1;

    // Reset for two cycles.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_dut0", {u_if0.ser_out, u_if0.busy, u_if0.din_ready, u_if0.done}, 4'b1010);
    check("reset_dut1", {u_if1.ser_out, u_if1.busy, u_if1.din_ready, u_if1.done}, 4'b1010);
    repeat (3) @(posedge clk);

    // 0xA5: plain frame and even-parity frame (four ones, parity 0).
    log_q.delete();
    logging = 1'b1;
    send_pulse(8'hA5);
    wait_idle("idle_a5");
    repeat (6) @(negedge clk);
    logging = 1'b0;
    frame_check("a5_dut0", 0, "0101001011");
    frame_check("a5_dut1", 1, "01010010101");

    // 0x07: three ones, so the parity bit is 1.
    log_q.delete();
    logging = 1'b1;
    send_pulse(8'h07);
    wait_idle("idle_07");
    repeat (6) @(negedge clk);
    logging = 1'b0;
    frame_check("x07_dut0", 0, "0111000001");
    frame_check("x07_dut1", 1, "01110000011");

    // din_valid held while din keeps changing; the model holds the latched word.
    @(posedge clk); #1;
    din_valid = 1'b1;
    din = 8'h11;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      din = din * 8'd5 + 8'd3;
    end
    din_valid = 1'b0;
    wait_idle("idle_hold");

    // Back-to-back: 0x3C then 0xC3 with din_valid held.
    @(posedge clk); #1;
    din = 8'h3C;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din = 8'hC3;
    n = 0;
    @(negedge clk);
    while (u_if0.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done0_seen", 32'(n < 200), 32'd1);
    check("b2b_ready_at_done", 32'(u_if0.din_ready), 32'd1);
    @(negedge clk);
    check("b2b_busy_after_done", 32'(u_if0.busy), 32'd1);
    n = 0;
    while (u_if1.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b2b_done1_seen", 32'(n < 200), 32'd1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    wait_idle("idle_b2b");

    // Reset while the line is showing data bit 3.
    send_pulse(8'h5A);
    n = 0;
    @(negedge clk);
    while (u_if0.ser_out !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_start_seen", 32'(n < 50), 32'd1);
    n = 0;
    for (int t = 0; t < 4 && n < 50; ) begin
      @(posedge clk);
      if (tick_en) t++;
      n++;
    end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_dut0", {u_if0.ser_out, u_if0.busy, u_if0.din_ready}, 3'b101);
    check("rst_mid_dut1", {u_if1.ser_out, u_if1.busy, u_if1.din_ready}, 3'b101);
    snap0 = dc0;
    snap1 = dc1;
    repeat (60) @(negedge clk);
    check("rst_no_done0", 32'(dc0 - snap0), 32'd0);
    check("rst_no_done1", 32'(dc1 - snap1), 32'd0);

    repeat (4) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/tx_shift.md
TX_SHIFT -- requirements
Module: tx_shift

Interface
REQ-001 Parameter DATA_W, default 8: width of one data word, legal range 5..16.
REQ-002 Parameter PARITY_EN, default 0: when 1, an even-parity bit is inserted between the last data bit and the stop bit.
REQ-003 clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 tick_en  input  1  one-cycle bit-rate strobe from the upstream clock divider (nominally 1 of every 4 cycles); any spacing of 2 or more cycles is legal.
REQ-006 din_valid  input  1  upstream word available.
REQ-007 din  input  DATA_W  word to transmit; sampled only on acceptance.
REQ-008 din_ready  output  1  high when a word can be accepted.
REQ-009 ser_out  output  1  registered serial line; idle level is 1.
REQ-010 busy  output  1  high whenever a frame is pending or in progress.
REQ-011 done  output  1  one-cycle pulse marking the end of a frame.

Function
REQ-012 States SHALL be IDLE, ARM, START, DATA, PAR and STOP; PAR SHALL be reachable only when PARITY_EN=1.
REQ-013 din_ready SHALL equal (state==IDLE), and busy SHALL equal (state!=IDLE).
REQ-014 Acceptance SHALL occur on a rising edge where din_valid and din_ready are both 1: din is latched into the shift register and the state goes to ARM.
REQ-015 A tick_en in the acceptance cycle SHALL be ignored, so framing starts only on a strictly later tick.
REQ-016 In ARM, on tick_en: ser_out<=0 and the state goes to START (start-bit edge aligned to a tick).
REQ-017 In START, on tick_en: ser_out<=data bit 0 (LSB first), bit counter<=0 and the state goes to DATA.
REQ-018 In DATA, on tick_en: if counter<DATA_W-1, output the next bit and increment the counter; otherwise output the parity bit and go to PAR (PARITY_EN=1), or output 1 and go to STOP (PARITY_EN=0).
REQ-019 The parity bit SHALL be the XOR of all DATA_W bits of the latched word (even parity).
REQ-020 In PAR, on tick_en: ser_out<=1 and the state goes to STOP.
REQ-021 In STOP, on tick_en: the state goes to IDLE, done<=1 for exactly one cycle, and ser_out stays 1.
REQ-022 Without tick_en, the state and ser_out SHALL hold; every bit lasts exactly one tick interval, and the line holds the idle level while in IDLE and ARM.
REQ-023 din_valid and din SHALL be ignored while busy; the latched word SHALL NOT change mid-frame.
REQ-024 Back-to-back frames: a word presented while done=1 SHALL be accepted in that cycle (state already IDLE).
REQ-025 The counter SHALL be wide enough for DATA_W-1 and SHALL never wrap within a frame.
REQ-026 Total frame length from the ARM exit tick to the IDLE entry tick SHALL be DATA_W+2 ticks (DATA_W+3 with parity).

Reset
REQ-027 While rst=1 at a clock edge: state<=IDLE, ser_out<=1, done<=0, counter<=0 and shift register<=0, overriding tick_en and din_valid.
REQ-028 A reset mid-frame SHALL abort the frame without a done pulse; ser_out=1 and din_ready=1 SHALL hold from the cycle after the reset edge.

Verification
REQ-029 Reset: assert rst for 2 cycles -> ser_out=1, din_ready=1, busy=0, done=0.
REQ-030 PARITY_EN=0, tick every 4 cycles, send 0xA5 -> ser_out shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; then one done pulse and din_ready=1.
REQ-031 PARITY_EN=1, send 0x07 -> the bit after the 8 data bits is 1, followed by stop bit 1; the frame spans 11 ticks.
REQ-032 Hold din_valid=1 with din changing throughout the frame -> no second acceptance until IDLE, and the transmitted bits match the word latched at acceptance.
REQ-033 Back-to-back 0x3C then 0xC3 with din_valid held -> the second word is accepted in the done cycle, and both frames are contiguous apart from ARM idle time.
REQ-034 rst asserted during DATA bit 3 -> the next cycle shows ser_out=1, busy=0, din_ready=1, and no done pulse occurs.
